regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_pkg.sv | 22 ++
 rtl/regfile_scoreboard_counter.sv | 46 ++++
 rtl/regfile_scoreboard.sv | 134 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_scoreboard_pkg
// Brief  : Shared defaults, index width and register-name aliases for the
//          register file with write-pending scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
package regfile_scoreboard_pkg;

   localparam int NUM_REGS_DEFAULT  = 8;
   localparam int WORD_SIZE_DEFAULT = 16;
   localparam int REG_BITS          = $clog2(NUM_REGS_DEFAULT);

   // The top three architectural registers carry fixed roles; PC is the last.
   typedef enum logic [REG_BITS-1:0] {
      REG_LR = REG_BITS'(NUM_REGS_DEFAULT - 3),
      REG_SP = REG_BITS'(NUM_REGS_DEFAULT - 2),
      REG_PC = REG_BITS'(NUM_REGS_DEFAULT - 1)
   } reg_name_e;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_counter.sv
`default_nettype none
// ============================================================================
// Module : sb_counter
// Brief  : Per-register pending-write counter. Adds one accepted issue and
//          subtracts the number of same-cycle writebacks, clamping at zero.
// Rev    : 1.0  initial release
// ============================================================================
module sb_counter #(
   parameter int PEND_BITS = 2,
   parameter int HIT_BITS  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 inc,
   input  logic [HIT_BITS-1:0]  dec,
   output logic [PEND_BITS-1:0] count,
   output logic                 underflow
);

   // One spare bit so count+1 never wraps before the subtraction.
   localparam int SUM_BITS = ((PEND_BITS > HIT_BITS) ? PEND_BITS : HIT_BITS) + 1;

   logic [SUM_BITS-1:0] sum;
   logic [SUM_BITS-1:0] dec_ext;
   logic [SUM_BITS-1:0] next_count;

   // Net arithmetic for this cycle, clamping at zero and flagging the clamp.
   always_comb begin
      sum        = SUM_BITS'(count) + SUM_BITS'(inc);
      dec_ext    = SUM_BITS'(dec);
      underflow  = (sum < dec_ext);
      next_count = underflow ? '0 : (sum - dec_ext);
   end

   // Counter register; holds whenever the block is disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (enable) begin
         count <= next_count[PEND_BITS-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : regfile_scoreboard
// Brief  : Multi-port register file with zero-latency writeback bypass,
//          per-register pending-write scoreboard and PC in the top register.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int NUM_REGS  = NUM_REGS_DEFAULT,
   parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
   parameter int NUM_RD    = 2,
   parameter int NUM_WB    = 2,
   parameter int PEND_BITS = 2,
   localparam int RB       = $clog2(NUM_REGS)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             enable,
   input  logic [NUM_RD-1:0][RB-1:0]        rd_addr,
   output logic [NUM_RD-1:0][WORD_SIZE-1:0] rd_data,
   output logic [NUM_RD-1:0]                rd_ready,
   input  logic                             issue_valid,
   input  logic [RB-1:0]                    issue_reg,
   output logic                             issue_stall,
   input  logic [NUM_WB-1:0]                wb_valid,
   input  logic [NUM_WB-1:0][RB-1:0]        wb_reg,
   input  logic [NUM_WB-1:0][WORD_SIZE-1:0] wb_data,
   input  logic                             pc_advance,
   input  logic                             pc_load,
   input  logic [WORD_SIZE-1:0]             pc_value,
   output logic [WORD_SIZE-1:0]             pc_out,
   output logic                             err_underflow
);

   localparam int HIT_BITS = $clog2(NUM_WB + 1);
   localparam int CMP_BITS = ((PEND_BITS > HIT_BITS) ? PEND_BITS : HIT_BITS);
   localparam int PC_IDX   = NUM_REGS - 1;

   logic [WORD_SIZE-1:0] regs      [NUM_REGS];
   logic [HIT_BITS-1:0]  hits      [NUM_REGS];
   logic                 wr_en     [NUM_REGS];
   logic [WORD_SIZE-1:0] wr_data   [NUM_REGS];
   logic                 issue_hit [NUM_REGS];
   logic [PEND_BITS-1:0] pend      [NUM_REGS];
   logic [NUM_REGS-1:0]  underflow;
   logic                 issue_ok;

   // A saturated counter can only take a new claim if a writeback drains it.
   assign issue_stall = issue_valid && (pend[issue_reg] == '1) && (hits[issue_reg] == '0);
   assign issue_ok    = issue_valid && !issue_stall;
   assign pc_out      = regs[PC_IDX];

   // Per-register writeback decode; later ports override earlier ones.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         hits[r]      = '0;
         wr_en[r]     = 1'b0;
         wr_data[r]   = '0;
         issue_hit[r] = issue_ok && (issue_reg == RB'(r));
         for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i] && (wb_reg[i] == RB'(r))) begin
               hits[r]    = hits[r] + HIT_BITS'(1);
               wr_en[r]   = 1'b1;
               wr_data[r] = wb_data[i];
            end
         end
      end
   end

   // Read ports: bypass the winning writeback, forced to zero under reset.
   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         rd_ready[k] = (CMP_BITS'(pend[rd_addr[k]]) <= CMP_BITS'(hits[rd_addr[k]]));
         if (!rst_n) begin
            rd_data[k] = '0;
         end else if (enable && wr_en[rd_addr[k]]) begin
            rd_data[k] = wr_data[rd_addr[k]];
         end else begin
            rd_data[k] = regs[rd_addr[k]];
         end
      end
   end

   // Register storage; the top register doubles as the PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
         end
      end else if (enable) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (r == PC_IDX) begin
               if (wr_en[r]) begin
                  regs[r] <= wr_data[r];
               end else if (pc_load) begin
                  regs[r] <= pc_value;
               end else if (pc_advance) begin
                  regs[r] <= regs[r] + WORD_SIZE'(1);
               end
            end else if (wr_en[r]) begin
               regs[r] <= wr_data[r];
            end
         end
      end
   end

   // Sticky underflow flag, set when any counter clamps in an enabled cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_underflow <= 1'b0;
      end else if (enable && (|underflow)) begin
         err_underflow <= 1'b1;
      end
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
      sb_counter #(
         .PEND_BITS (PEND_BITS),
         .HIT_BITS  (HIT_BITS)
      ) u_cnt (
         .clk       (clk),
         .rst_n     (rst_n),
         .enable    (enable),
         .inc       (issue_hit[r]),
         .dec       (hits[r]),
         .count     (pend[r]),
         .underflow (underflow[r])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_scoreboard
// Brief  : Scoreboard bench: driver pushes model expectations per cycle, a
//          monitor pops and compares the DUT outputs on the falling edge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_regfile_scoreboard;

   localparam int NR = 8;
   localparam int WS = 16;
   localparam int RB = 3;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 enable;
   logic [1:0][RB-1:0]   rd_addr;
   logic [1:0][WS-1:0]   rd_data;
   logic [1:0]           rd_ready;
   logic                 issue_valid;
   logic [RB-1:0]        issue_reg;
   logic                 issue_stall;
   logic [1:0]           wb_valid;
   logic [1:0][RB-1:0]   wb_reg;
   logic [1:0][WS-1:0]   wb_data;
   logic                 pc_advance;
   logic                 pc_load;
   logic [WS-1:0]        pc_value;
   logic [WS-1:0]        pc_out;
   logic                 err_underflow;

   typedef struct {
      logic [1:0][WS-1:0] rd;
      logic [1:0]         rdy;
      logic               stall;
      logic [WS-1:0]      pc;
      logic               err;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference state: architectural contents and outstanding-write counts.
   logic [WS-1:0] m_regs [NR];
   int            m_pend [NR];
   logic          m_err;

   regfile_scoreboard dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_ready      (rd_ready),
      .issue_valid   (issue_valid),
      .issue_reg     (issue_reg),
      .issue_stall   (issue_stall),
      .wb_valid      (wb_valid),
      .wb_reg        (wb_reg),
      .wb_data       (wb_data),
      .pc_advance    (pc_advance),
      .pc_load       (pc_load),
      .pc_value      (pc_value),
      .pc_out        (pc_out),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [WS-1:0] act, input logic [WS-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Compute this cycle's expected outputs, queue them, then advance the model.
   task automatic apply();
      exp_t          e;
      int            hits [NR];
      logic [WS-1:0] win  [NR];
      bit            wrote[NR];
      bit            stall;
      int            p;
      if (!rst_n) begin
         for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
         end
         m_err = 1'b0;
      end
      for (int r = 0; r < NR; r++) begin
         hits[r] = 0; wrote[r] = 0; win[r] = '0;
      end
      for (int i = 0; i < 2; i++) begin
         if (wb_valid[i]) begin
            hits[wb_reg[i]]++;
            wrote[wb_reg[i]] = 1;
            win[wb_reg[i]]   = wb_data[i];
         end
      end
      stall = issue_valid && (m_pend[issue_reg] == 3) && (hits[issue_reg] == 0);
      for (int k = 0; k < 2; k++) begin
         if (!rst_n)                         e.rd[k] = '0;
         else if (enable && wrote[rd_addr[k]]) e.rd[k] = win[rd_addr[k]];
         else                                e.rd[k] = m_regs[rd_addr[k]];
         e.rdy[k] = (m_pend[rd_addr[k]] <= hits[rd_addr[k]]);
      end
      e.stall = stall;
      e.pc    = m_regs[NR-1];
      e.err   = m_err;
      exp_q.push_back(e);
      if (rst_n && enable) begin
         for (int r = 0; r < NR; r++) begin
            p = m_pend[r] + ((issue_valid && !stall && issue_reg == r) ? 1 : 0) - hits[r];
            if (p < 0) begin
               p = 0;
               m_err = 1'b1;
            end
            m_pend[r] = p;
         end
         if (wrote[NR-1])    m_regs[NR-1] = win[NR-1];
         else if (pc_load)    m_regs[NR-1] = pc_value;
         else if (pc_advance) m_regs[NR-1] = m_regs[NR-1] + 16'd1;
         for (int r = 0; r < NR-1; r++) begin
            if (wrote[r]) m_regs[r] = win[r];
         end
      end
   endtask

   task automatic idle();
      enable = 1'b1; rd_addr = '0; issue_valid = 1'b0; issue_reg = '0;
      wb_valid = '0; wb_reg = '0; wb_data = '0;
      pc_advance = 1'b0; pc_load = 1'b0; pc_value = '0;
   endtask

   // Start of a cycle: inputs change just after the rising edge.
   task automatic cyc_start();
      @(posedge clk);
      #1;
      idle();
   endtask

   // Monitor: every cycle with a queued expectation is compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rd_data0", rd_data[0], e.rd[0]);
            check("rd_data1", rd_data[1], e.rd[1]);
            check("rd_ready", WS'(rd_ready), WS'(e.rdy));
            check("issue_stall", WS'(issue_stall), WS'(e.stall));
            check("pc_out", pc_out, e.pc);
            check("err_underflow", WS'(err_underflow), WS'(e.err));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      for (int i = 0; i < 3; i++) begin cyc_start(); rst_n = 1'b0; apply(); end
      cyc_start(); rst_n = 1'b1; apply();

      // Issue r3, WB r3 two cycles later, watching readiness.
      cyc_start(); rd_addr = {3'd3, 3'd3}; issue_valid = 1; issue_reg = 3; apply();
      cyc_start(); rd_addr = {3'd3, 3'd3}; apply();
      cyc_start(); rd_addr = {3'd3, 3'd3}; apply();
      cyc_start(); rd_addr = {3'd3, 3'd3}; wb_valid = 2'b01; wb_reg[0] = 3; wb_data[0] = 16'h00AA; apply();
      cyc_start(); rd_addr = {3'd3, 3'd3}; apply();

      // Saturate r2, stalled fourth issue, then accepted with a concurrent WB.
      for (int i = 0; i < 4; i++) begin
         cyc_start(); rd_addr = {3'd2, 3'd2}; issue_valid = 1; issue_reg = 2; apply();
      end
      cyc_start(); rd_addr = {3'd2, 3'd2}; issue_valid = 1; issue_reg = 2;
      wb_valid = 2'b01; wb_reg[0] = 2; wb_data[0] = 16'h5A5A; apply();
      cyc_start(); rd_addr = {3'd2, 3'd2}; issue_valid = 1; issue_reg = 2; apply();

      // Two ports hit r1 with two pending writes; highest port wins.
      for (int i = 0; i < 2; i++) begin
         cyc_start(); issue_valid = 1; issue_reg = 1; apply();
      end
      cyc_start(); rd_addr = {3'd1, 3'd1}; wb_valid = 2'b11; wb_reg = {3'd1, 3'd1};
      wb_data = {16'h2222, 16'h1111}; apply();
      cyc_start(); rd_addr = {3'd1, 3'd1}; apply();

      // PC wrap, load over advance, WB to PC over load.
      cyc_start(); pc_load = 1; pc_value = 16'hFFFF; apply();
      cyc_start(); pc_advance = 1; apply();
      cyc_start(); pc_load = 1; pc_value = 16'h0040; pc_advance = 1; apply();
      cyc_start(); pc_load = 1; pc_value = 16'h1234; wb_valid = 2'b10; wb_reg[1] = 7; wb_data[1] = 16'h0100; apply();
      cyc_start(); rd_addr = {3'd7, 3'd7}; apply();

      // Disabled cycle must hold everything.
      cyc_start(); enable = 0; pc_advance = 1; issue_valid = 1; issue_reg = 5; wb_valid = 2'b01; wb_reg[0] = 6; apply();
      cyc_start(); rd_addr = {3'd6, 3'd5}; apply();

      // Underflow on r4, flag sticks, then reset mid-operation.
      cyc_start(); rd_addr = {3'd4, 3'd4}; wb_valid = 2'b01; wb_reg[0] = 4; wb_data[0] = 16'hBEEF; apply();
      for (int i = 0; i < 3; i++) begin cyc_start(); rd_addr = {3'd4, 3'd4}; pc_advance = 1; apply(); end
      cyc_start(); rst_n = 0; rd_addr = {3'd4, 3'd7}; wb_valid = 2'b11; wb_reg = {3'd4, 3'd4};
      wb_data = {16'hAAAA, 16'h5555}; issue_valid = 1; issue_reg = 4; apply();
      cyc_start(); rst_n = 1; rd_addr = {3'd4, 3'd7}; apply();

      // Randomized traffic with occasional mid-run resets.
      for (int n = 0; n < 1500; n++) begin
         cyc_start();
         rst_n       = ($urandom_range(0, 99) != 0);
         enable      = ($urandom_range(0, 9) != 0);
         rd_addr[0]  = RB'($urandom_range(0, NR-1));
         rd_addr[1]  = RB'($urandom_range(0, NR-1));
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_reg   = RB'($urandom_range(0, NR-1));
         wb_valid[0] = ($urandom_range(0, 4) < 2);
         wb_valid[1] = ($urandom_range(0, 4) < 2);
         wb_reg[0]   = RB'($urandom_range(0, NR-1));
         wb_reg[1]   = RB'($urandom_range(0, NR-1));
         wb_data[0]  = WS'($urandom);
         wb_data[1]  = WS'($urandom);
         pc_advance  = ($urandom_range(0, 1) == 1);
         pc_load     = ($urandom_range(0, 9) == 0);
         pc_value    = WS'($urandom);
         apply();
      end

      @(negedge clk);
      #1;
      check("queue_drained", WS'(exp_q.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
